// File: rtl/distortion_i2s_out.sv
// Float32 -> saturated Q1.23 PCM, small FIFO, mono-duplicated I2S serializer.
// Define OUT_ROUND_EN for round-half-away-from-zero conversion instead of truncation.
module distortion_i2s_out #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          aclr_n,
    input  logic [31:0]                   sample_in,
    input  logic                          sample_valid,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          fifo_overflow,
    output logic                          fifo_underflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {
        PRIME,
        STREAM
    } state_e;

    function automatic logic [23:0] to_pcm(input logic [31:0] f);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [6:0]  sh;
        logic [24:0] mant;
        logic [24:0] mag;
        s      = f[31];
        e      = f[30:23];
        m      = f[22:0];
        sh     = 7'(8'd127 - e);
        mant   = {2'b01, m};
        mag    = '0;
        to_pcm = '0;
        if (e == 8'hff) begin
            if (m == '0) begin
                to_pcm = s ? 24'h800001 : 24'h7fffff;
            end
        end else if (e == 8'h00) begin
            to_pcm = '0;
        end else if (e >= 8'd127) begin
            to_pcm = s ? 24'h800001 : 24'h7fffff;
        end else begin
`ifdef OUT_ROUND_EN
            if (sh <= 7'd24) begin
                mant = mant + (25'd1 << (sh - 7'd1));
            end
`endif
            mag = mant >> sh;
            // A rounding carry into 2^23 must clip, never reach 0x800000
            if (mag[24] || mag[23]) begin
                to_pcm = s ? 24'h800001 : 24'h7fffff;
            end else begin
                to_pcm = s ? (24'd0 - mag[23:0]) : mag[23:0];
            end
        end
    endfunction

    logic [31:0]   in_q, in_d;
    logic          in_v_q, in_v_d;
    logic [23:0]   pcm_q, pcm_d;
    logic          pcm_v_q, pcm_v_d;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [23:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    state_e        state_q, state_d;
    logic [23:0]   held_q, held_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          wrap, fall, frame_start;
    logic          full, empty, pop, push;
    logic [4:0]    k;
    logic [23:0]   word;

    always_comb begin
        in_d      = sample_valid ? sample_in : in_q;
        in_v_d    = sample_valid;
        pcm_d     = in_v_q ? to_pcm(in_q) : pcm_q;
        pcm_v_d   = in_v_q;
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bclk_d    = bclk_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        bit_cnt_d = bit_cnt_q;
        state_d   = state_q;
        held_d    = held_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        wrap        = (clk_cnt_q == CW'(CLK_DIV - 1));
        fall        = wrap && bclk_q;
        frame_start = fall && (bit_cnt_q == 6'd63);
        full        = (cnt_q == (PW+1)'(FIFO_DEPTH));
        empty       = (cnt_q == '0);
        word        = (state_q == STREAM) ? held_q : 24'd0;
        k           = 5'(bit_cnt_q + 6'd1);

        if (wrap) begin
            clk_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
        if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrclk_d   = bit_cnt_d[5];
            sdata_d   = (k >= 5'd1 && k <= 5'd24) ? word[5'd24 - k] : 1'b0;
        end

        pop = 1'b0;
        if (frame_start) begin
            if (state_q == PRIME) begin
                pop = (cnt_q >= (PW+1)'(2));
            end else begin
                pop = !empty;
                if (empty) begin
                    unf_d = 1'b1;
                end
            end
        end
        if (pop) begin
            held_d  = mem_q[rptr_q];
            rptr_d  = rptr_q + PW'(1);
            state_d = STREAM;
        end

        // A pop on the same edge frees the slot, so full+pop still accepts
        push = pcm_v_q && (!full || pop);
        if (pcm_v_q && !push) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            mem_d[wptr_q] = pcm_q;
            wptr_d        = wptr_q + PW'(1);
        end
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            in_q      <= '0;
            in_v_q    <= 1'b0;
            pcm_q     <= '0;
            pcm_v_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            clk_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b1;
            sdata_q   <= 1'b0;
            bit_cnt_q <= 6'd63;
            state_q   <= PRIME;
            held_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            in_q      <= in_d;
            in_v_q    <= in_v_d;
            pcm_q     <= pcm_d;
            pcm_v_q   <= pcm_v_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            clk_cnt_q <= clk_cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            bit_cnt_q <= bit_cnt_d;
            state_q   <= state_d;
            held_q    <= held_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign bclk           = bclk_q;
    assign lrclk          = lrclk_q;
    assign sdata          = sdata_q;
    assign fill_level     = cnt_q;
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;

endmodule

// File: tb/tb_distortion_i2s_out.sv
// Scoreboard bench for distortion_i2s_out: real-arithmetic conversion model,
// queue FIFO model, and a frame monitor decoding the I2S stream.
module tb_distortion_i2s_out;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic [31:0]   sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          bclk, lrclk, sdata;
    logic [FW-1:0] fill_level;
    logic          fifo_overflow, fifo_underflow;

    distortion_i2s_out #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk),
        .aclr_n(aclr_n),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .bclk(bclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .fill_level(fill_level),
        .fifo_overflow(fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [23:0] exp_q[$];
    logic        primed = 1'b0;
    logic [23:0] hold = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_unf = 1'b0;
    logic [23:0] fexp = '0;
    int          frames = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value of the float in LSB units of Q1.23, then rounded/truncated and clipped
    function automatic logic [23:0] model_pcm(input logic [31:0] f);
        int  e;
        int  m;
        real x;
        int  mag;
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        if (e == 255 && m != 0) return 24'd0;
        if (e == 0) return 24'd0;
        if (e == 255) x = 1.0e9;
        else x = real'(8388608 + m) / (2.0 ** (127 - e));
        if (x >= 8388607.0) mag = 8388607;
`ifdef OUT_ROUND_EN
        else mag = $rtoi(x + 0.5);
`else
        else mag = $rtoi(x);
`endif
        if (mag > 8388607) mag = 8388607;
        if (f[31]) mag = -mag;
        return mag[23:0];
    endfunction

    task automatic send(input logic [31:0] f);
        sample_in    = f;
        sample_valid = 1'b1;
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(model_pcm(f));
        else exp_ovf = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        primed  = 1'b0;
        hold    = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic wait_mid();
        int n;
        n = 0;
        while (lrclk !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        while (lrclk !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        tests++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL wait_mid: got timeout after %0d cycles required lrclk rise", n);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_frames(input int nf);
        int target;
        int n;
        target = frames + nf;
        n = 0;
        while (frames < target && n < 600 * nf) begin @(negedge clk); n++; end
        tests++;
        if (frames < target) begin
            fails++;
            $display("FAIL frame_timeout: got %0d frames required %0d", frames, target);
        end
    endtask

    // Frame monitor: samples the stream where the DAC would, on bclk rises
    logic        pb = 1'b0;
    logic        plr = 1'b1;
    int          kk = -1;
    logic [63:0] bits = '0;
    logic        lr_err = 1'b0;

    always @(negedge clk) begin
        if (!aclr_n) begin
            pb     = 1'b0;
            plr    = 1'b1;
            kk     = -1;
            lr_err = 1'b0;
        end else begin
            if (bclk && !pb) begin
                if (plr && !lrclk) begin
                    kk     = 0;
                    lr_err = 1'b0;
                    if (!primed) begin
                        if (exp_q.size() >= 2) begin
                            primed = 1'b1;
                            hold   = exp_q.pop_front();
                        end
                    end else if (exp_q.size() > 0) begin
                        hold = exp_q.pop_front();
                    end else begin
                        exp_unf = 1'b1;
                    end
                    fexp = primed ? hold : 24'd0;
                end else if (kk >= 0) begin
                    kk++;
                end
                if (kk >= 0 && kk < 64) begin
                    bits[kk] = sdata;
                    if (lrclk !== (kk >= 32)) lr_err = 1'b1;
                end
                if (kk == 63) begin
                    logic [23:0] l, r;
                    logic        pad;
                    for (int i = 0; i < 24; i++) begin
                        l[23-i] = bits[1+i];
                        r[23-i] = bits[33+i];
                    end
                    pad = bits[0] | bits[32] | (|bits[31:25]) | (|bits[63:57]);
                    check("left_word", {8'd0, l}, {8'd0, fexp});
                    check("right_word", {8'd0, r}, {8'd0, fexp});
                    check("pad_bits", {31'd0, pad}, 32'd0);
                    check("lrclk_slot", {31'd0, lr_err}, 32'd0);
                    check("underflow", {31'd0, fifo_underflow}, {31'd0, exp_unf});
                    check("overflow", {31'd0, fifo_overflow}, {31'd0, exp_ovf});
                    check("fill_level", 32'(fill_level), 32'(exp_q.size()));
                    frames++;
                    kk = -1;
                end
                plr = lrclk;
            end
            pb = bclk;
        end
    end

    logic [31:0] specials [8];
    int          n;

    initial begin
        specials[0] = 32'h3F800000;
        specials[1] = 32'hC0000000;
        specials[2] = 32'h7F800000;
        specials[3] = 32'h7FC00000;
        specials[4] = 32'h00400000;
        specials[5] = 32'h33800000;
        specials[6] = 32'h3F7FFFFF;
        specials[7] = 32'hFF800000;

        repeat (3) @(negedge clk);
        check("rst_bclk", {31'd0, bclk}, 32'd0);
        check("rst_lrclk", {31'd0, lrclk}, 32'd1);
        check("rst_sdata", {31'd0, sdata}, 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_flags", {30'd0, fifo_overflow, fifo_underflow}, 32'd0);
        aclr_n = 1'b1;

        wait_frames(1);
        wait_mid();
        send(32'h3F000000);
        send(32'hBF000000);
        for (int i = 0; i < 8; i++) begin
            wait_mid();
            send(specials[i]);
        end
        for (int i = 0; i < 12; i++) begin
            logic [31:0] f;
            f = $urandom;
            if (i % 2 == 0) begin
                f[30:23] = 8'($urandom_range(100, 130));
            end
            wait_mid();
            send(f);
        end
        wait_frames(4);

        wait_mid();
        for (int i = 0; i < 6; i++) begin
            send({1'($urandom), 8'($urandom_range(110, 126)), 23'($urandom)});
        end
        repeat (4) @(negedge clk);
        check("burst_fill", 32'(fill_level), 32'(FIFO_DEPTH));
        check("burst_overflow", {31'd0, fifo_overflow}, 32'd1);
        wait_frames(6);

        wait_mid();
        repeat (48) @(negedge clk);
        aclr_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_bclk", {31'd0, bclk}, 32'd0);
        check("mid_rst_lrclk", {31'd0, lrclk}, 32'd1);
        check("mid_rst_sdata", {31'd0, sdata}, 32'd0);
        check("mid_rst_fill", 32'(fill_level), 32'd0);
        check("mid_rst_flags", {30'd0, fifo_overflow, fifo_underflow}, 32'd0);
        repeat (3) @(negedge clk);
        aclr_n = 1'b1;
        n = 0;
        while (lrclk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("first_fall_delay", 32'(n), 32'(2 * CLK_DIV));
        wait_frames(2);
        wait_mid();
        send(32'h3E800000);
        send(32'hBE800000);
        wait_frames(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
